// File: rtl/vector_check_engine_pkg.sv
// Shared types and constants for the vector check engine.
// Holds the FSM state encoding and the latency ceiling.
package vector_check_engine_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int LAT_MAX = 7;

  // Width of a counter able to hold 0..LAT_MAX.
  localparam int DRAIN_W = $clog2(LAT_MAX + 1);

endpackage

// File: rtl/vector_check_engine_delay.sv
// vcheck_delay: LAT-stage {valid, index} shift register.
// Ports: clk, rst_n, flush, in_valid/in_idx -> out_valid/out_idx.
module vcheck_delay
  import vector_check_engine_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int LAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_idx,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_idx
);

  if (LAT == 0) begin : g_wire
    // No storage at zero latency; clock and
    // clears have nothing to act on.
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, flush};

    assign out_valid = in_valid;
    assign out_idx   = in_idx;
  end else begin : g_pipe
    logic [LAT-1:0]   v_q;
    logic [WIDTH-1:0] idx_q [LAT];

    always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
        v_q <= '0;
        for (int i = 0; i < LAT; i++) begin
          idx_q[i] <= '0;
        end
      end else begin
        v_q[0]   <= in_valid;
        idx_q[0] <= in_idx;
        for (int i = 1; i < LAT; i++) begin
          v_q[i]   <= v_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end
    end

    assign out_valid = v_q[LAT-1];
    assign out_idx   = idx_q[LAT-1];
  end

endmodule

// File: rtl/vector_check_engine.sv
// Exhaustive stimulus sweep comparing a model under test
// against a golden model; reports count and first failure.
// Ports: clk, rst_n, start in; vec out to both models;
// q_m/a_m responses in; busy, done, pass, err_cnt,
// first_fail, fail_valid status out.
module vector_check_engine
  import vector_check_engine_pkg::*;
#(
  parameter int WIDTH        = 5,
  parameter int OUT_W        = 1,
  parameter int LAT          = 0,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] vec,
  input  logic [OUT_W-1:0] q_m,
  input  logic [OUT_W-1:0] a_m,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_cnt,
  output logic [WIDTH-1:0] first_fail,
  output logic             fail_valid
);

  localparam logic [WIDTH-1:0] VEC_MAX = '1;

  localparam logic [DRAIN_W-1:0] DRAIN_INIT =
    DRAIN_W'((LAT > 0) ? LAT - 1 : 0);

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;

  logic             cmp_valid;
  logic [WIDTH-1:0] cmp_idx;
  logic             hit;
  logic             stop;
  logic [WIDTH:0]   err_nxt;

  assign hit  = cmp_valid && (q_m != a_m);
  assign stop = hit && (STOP_ON_FAIL != 0);

  assign err_nxt =
    err_cnt + {{WIDTH{1'b0}}, hit};

  // Each vector enters the delay line the cycle it is
  // driven and pops out when its responses are valid.
  vcheck_delay #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (stop),
    .in_valid  (state == RUN),
    .in_idx    (vec),
    .out_valid (cmp_valid),
    .out_idx   (cmp_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;

      if (hit) begin
        err_cnt <= err_nxt;
        if (!fail_valid) begin
          first_fail <= cmp_idx;
          fail_valid <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            vec        <= '0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
          end
        end

        RUN: begin
          if (stop) begin
            // vec stays on the failing vector.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else if (vec == VEC_MAX) begin
            if (LAT > 0) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_INIT;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == '0);
            end
          end else begin
            vec <= vec + WIDTH'(1);
          end
        end

        DRAIN: begin
          if (stop || drain_cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_check_engine.sv
// Self-checking bench: three engine instances
// (LAT0, LAT0 stop-on-fail, LAT2) driven by table models.
module tb_vector_check_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start   [3];
  logic [4:0] vec_o   [3];
  logic [0:0] q_m     [3];
  logic [0:0] a_m     [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic       pass_o  [3];
  logic [5:0] err_o   [3];
  logic [4:0] first_o [3];
  logic       fv_o    [3];

  vector_check_engine #(
    .WIDTH(5), .OUT_W(1), .LAT(0), .STOP_ON_FAIL(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .vec(vec_o[0]), .q_m(q_m[0]), .a_m(a_m[0]),
    .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .err_cnt(err_o[0]),
    .first_fail(first_o[0]), .fail_valid(fv_o[0])
  );

  vector_check_engine #(
    .WIDTH(5), .OUT_W(1), .LAT(0), .STOP_ON_FAIL(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .vec(vec_o[1]), .q_m(q_m[1]), .a_m(a_m[1]),
    .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .err_cnt(err_o[1]),
    .first_fail(first_o[1]), .fail_valid(fv_o[1])
  );

  vector_check_engine #(
    .WIDTH(5), .OUT_W(1), .LAT(2), .STOP_ON_FAIL(0)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]),
    .vec(vec_o[2]), .q_m(q_m[2]), .a_m(a_m[2]),
    .busy(busy_o[2]), .done(done_o[2]),
    .pass(pass_o[2]), .err_cnt(err_o[2]),
    .first_fail(first_o[2]), .fail_valid(fv_o[2])
  );

  // Behavioural models: golden and question truth tables.
  bit gold [32];
  bit ques [32];
  bit skew = 1'b0;

  logic [4:0] vd1 = '0;
  logic [4:0] vd2 = '0;
  always @(posedge clk) begin
    vd1 <= vec_o[2];
    vd2 <= vd1;
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      a_m[k] = gold[vec_o[k]];
      q_m[k] = ques[vec_o[k]];
    end
    a_m[2] = skew ? gold[vec_o[2]] : gold[vd2];
    q_m[2] = ques[vd2];
  end

  typedef struct {
    int err;
    int first;
    bit fv;
    bit pass;
    int cycles;
    int vfin;
  } exp_t;

  typedef struct {
    int   id;
    bit   skew;
    int   pat;
    int   f0;
    int   f1;
    exp_t e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic setup(input int pat,
                       input int f0, input int f1);
    for (int i = 0; i < 32; i++) begin
      gold[i] = (pat != 0) ? bit'((i >> 1) & 1) : 1'b0;
      ques[i] = gold[i];
    end
    if (f0 >= 0) ques[f0] = ~ques[f0];
    if (f1 >= 0) ques[f1] = ~ques[f1];
  endtask

  // Reference: walk all 32 vectors, pair each question
  // response with the golden response seen at compare time.
  function automatic exp_t model(input int id,
                                 input bit sk);
    exp_t e;
    int   ai;
    e.err = 0; e.first = 0; e.fv = 0;
    for (int i = 0; i < 32; i++) begin
      ai = (id == 2 && sk) ? ((i + 2 > 31) ? 31 : i + 2)
                           : i;
      if (gold[ai] != ques[i]) begin
        if (!e.fv) begin
          e.fv = 1;
          e.first = i;
        end
        e.err++;
        if (id == 1) break;
      end
    end
    e.pass = (e.err == 0);
    e.vfin = (id == 1 && e.fv) ? e.first : 31;
    e.cycles = (id == 1 && e.fv) ? e.first + 1
             : 32 + ((id == 2) ? 2 : 0);
    return e;
  endfunction

  function automatic logic [19:0] snap(input int k);
    return {vec_o[k], busy_o[k], done_o[k], pass_o[k],
            err_o[k], first_o[k], fv_o[k]};
  endfunction

  task automatic do_run(input int id, input exp_t e,
                        input int poke, input string tag);
    int n, vbad, bbad;
    bit seen;
    @(negedge clk);
    start[id] = 1'b1;
    @(posedge clk);
    n = 0; vbad = 0; bbad = 0; seen = 0;
    while (!seen && n <= 80) begin
      @(negedge clk);
      start[id] = (n == poke);
      if (done_o[id]) begin
        seen = 1;
      end else begin
        if (n <= e.vfin && vec_o[id] !== 5'(n)) vbad++;
        if (busy_o[id] !== 1'b1) bbad++;
        @(posedge clk);
        n++;
      end
    end
    start[id] = 1'b0;
    chk({tag, " latency"}, n, e.cycles);
    chk({tag, " vec_seq"}, vbad, 0);
    chk({tag, " busy_run"}, bbad, 0);
    chk({tag, " err_cnt"}, err_o[id], e.err);
    chk({tag, " pass"}, pass_o[id], e.pass);
    chk({tag, " fail_valid"}, fv_o[id], e.fv);
    if (e.fv) chk({tag, " first_fail"}, first_o[id], e.first);
    chk({tag, " vec_end"}, vec_o[id], e.vfin);
    chk({tag, " busy_done"}, busy_o[id], 0);
    // start during DONE must be ignored
    start[id] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[id] = 1'b0;
    chk({tag, " done_pulse"}, done_o[id], 0);
    chk({tag, " hold_err"}, err_o[id], e.err);
    chk({tag, " hold_pass"}, pass_o[id], e.pass);
    chk({tag, " hold_vec"}, vec_o[id], e.vfin);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " no_restart"}, busy_o[id], 0);
  endtask

  vec_t tbl [9];
  exp_t ex;
  int   n, d1, d2;

  initial begin
    for (int k = 0; k < 3; k++) start[k] = 1'b0;
    setup(0, -1, -1);

    tbl[0] = '{0, 0, 0, -1, -1, '{0, 0, 0, 1, 32, 31}};
    tbl[1] = '{0, 0, 0, 16, -1, '{1, 16, 1, 0, 32, 31}};
    tbl[2] = '{1, 0, 0, 16, -1, '{1, 16, 1, 0, 17, 16}};
    tbl[3] = '{2, 0, 0, -1, -1, '{0, 0, 0, 1, 34, 31}};
    tbl[4] = '{2, 1, 1, -1, -1, '{30, 0, 1, 0, 34, 31}};
    tbl[5] = '{0, 0, 0, 0, 31, '{2, 0, 1, 0, 32, 31}};
    tbl[6] = '{1, 0, 0, 31, -1, '{1, 31, 1, 0, 32, 31}};
    tbl[7] = '{1, 0, 0, 0, -1, '{1, 0, 1, 0, 1, 0}};
    tbl[8] = '{2, 0, 0, 31, -1, '{1, 31, 1, 0, 34, 31}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_state u%0d", k), snap(k), 0);
    rst_n = 1'b1;

    for (int t = 0; t < 9; t++) begin
      setup(tbl[t].pat, tbl[t].f0, tbl[t].f1);
      skew = tbl[t].skew;
      do_run(tbl[t].id, tbl[t].e, -1,
             $sformatf("tbl%0d", t));
    end

    // start pulsed mid-run at vec=5
    setup(0, 7, -1);
    skew = 0;
    do_run(0, '{1, 7, 1, 0, 32, 31}, 5, "poke5");

    // start held high restarts on each IDLE entry
    setup(0, -1, -1);
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    n = 0; d1 = -1; d2 = -1;
    while (n < 100 && d2 < 0) begin
      @(negedge clk);
      if (done_o[0]) begin
        if (d1 < 0) d1 = n;
        else begin
          d2 = n;
          start[0] = 1'b0;
        end
      end
      @(posedge clk);
      n++;
    end
    start[0] = 1'b0;
    chk("held_start first_done", d1, 32);
    chk("held_start second_done", d2, 66);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("held_start idle", busy_o[0], 0);

    // reset at vec=9 mid-run
    setup(0, 3, -1);
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    start[0] = 1'b0;
    while (vec_o[0] !== 5'd9 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_run pre_vec", vec_o[0], 9);
    chk("rst_run pre_fv", fv_o[0], 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_run state", snap(0), 0);
    rst_n = 1'b1;
    setup(0, -1, -1);
    do_run(0, '{0, 0, 0, 1, 32, 31}, -1, "after_rst");

    // reset in DRAIN of the LAT=2 engine
    setup(0, 31, -1);
    @(negedge clk);
    start[2] = 1'b1;
    @(posedge clk);
    #1 start[2] = 1'b0;
    repeat (33) @(posedge clk);
    @(negedge clk);
    chk("rst_drain pre_busy", busy_o[2], 1);
    chk("rst_drain pre_vec", vec_o[2], 31);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_drain state", snap(2), 0);
    rst_n = 1'b1;
    do_run(2, '{1, 31, 1, 0, 34, 31}, -1, "after_rst2");

    // randomized runs against the reference model
    for (int r = 0; r < 24; r++) begin
      int id;
      bit clean;
      id = $urandom_range(0, 2);
      skew = bit'($urandom_range(0, 1));
      clean = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 32; i++) begin
        gold[i] = bit'($urandom_range(0, 1));
        ques[i] = gold[i];
        if (!clean && $urandom_range(0, 7) == 0)
          ques[i] = ~gold[i];
      end
      ex = model(id, skew);
      do_run(id, ex, -1, $sformatf("rnd%0d_u%0d", r, id));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_check_engine.md
VECTOR_CHECK_ENGINE -- requirements
Module: vector_check_engine

Interface
REQ-001 Parameter WIDTH, default 5: number of stimulus bits, one per model input (a..e at default).
REQ-002 Parameter OUT_W, default 1: width of each model response (m at default).
REQ-003 Parameter LAT, default 0, range 0..7: latency in cycles from vec change to valid model response.
REQ-004 Parameter STOP_ON_FAIL, default 0: 1 = end the run at the first mismatch; 0 = run exhaustively.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  reset: synchronous, active-low.
REQ-007 start  in  1  run request; sampled only in IDLE.
REQ-008 vec  out  WIDTH  stimulus driven to both models; bit 0 = last model input (e at default).
REQ-009 q_m  in  OUT_W  response of the model under test (question).
REQ-010 a_m  in  OUT_W  response of the golden model (answer).
REQ-011 busy  out  1  high in RUN and DRAIN.
REQ-012 done  out  1  one-cycle pulse at run end.
REQ-013 pass  out  1  high when err_cnt is 0; valid from done until the next start.
REQ-014 err_cnt  out  WIDTH+1  number of mismatching vectors in the run.
REQ-015 first_fail  out  WIDTH  vec value of the first mismatch.
REQ-016 fail_valid  out  1  first_fail holds a captured value.

Function
REQ-017 The engine SHALL have states IDLE, RUN, DRAIN and DONE.
- IDLE to RUN on start=1, with vec=0; err_cnt, fail_valid and pass clear on the same edge.
- RUN: vec increments by 1 each cycle, from 0 to 2^WIDTH-1, with no wrap.
- After vec=2^WIDTH-1: to DRAIN if LAT>0, else to DONE.
- DRAIN: lasts exactly LAT cycles, then DONE.
- DONE: one cycle with done=1, then IDLE.
REQ-018 Each presented vector SHALL be compared exactly once: q_m against a_m, LAT cycles after presentation, tracked through a LAT-deep pipeline of (valid, index).
REQ-019 A mismatch (q_m != a_m, all OUT_W bits) SHALL increment err_cnt, which reaches a maximum of 2^WIDTH and needs no saturation.
REQ-020 The first mismatch of a run SHALL load first_fail with its index and set fail_valid; later mismatches leave both unchanged.
REQ-021 With STOP_ON_FAIL=1, the first mismatch SHALL move the state to DONE on the next edge, drop pending pipeline entries and freeze vec.
REQ-022 done SHALL assert exactly 2^WIDTH+LAT cycles after the edge that samples start, when no early stop occurs.
REQ-023 Final err_cnt, pass, first_fail and fail_valid SHALL be stable in the done cycle and SHALL hold until the next start.
REQ-024 start while busy or in DONE SHALL be ignored; start held high in IDLE SHALL begin a new run each time IDLE is re-entered.
REQ-025 vec SHALL hold its last value in DRAIN, DONE and IDLE.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force: state IDLE; vec=0; busy=0; done=0; pass=0; err_cnt=0; first_fail=0; fail_valid=0; pipeline cleared.
REQ-027 Reset SHALL take priority over start and over any in-flight comparison, including mid-RUN and mid-DRAIN.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, RUN, DRAIN, DONE) and the LAT_MAX=7 constant.
REQ-029 The comparison delay line SHALL be one sub-module, vcheck_delay, a parametrised LAT-stage shift register of {valid, index} that is a wire-through when LAT=0.

Verification
REQ-030 Setup WIDTH=5, LAT=0, identical models, pulse start -> vec steps 0..31, done 32 cycles after start, err_cnt=0, pass=1, fail_valid=0.
REQ-031 Setup WIDTH=5, LAT=0, golden model inverted only at vec=16 (a=1, others 0) -> err_cnt=1, first_fail=16, fail_valid=1, pass=0.
REQ-032 Setup as REQ-031 with STOP_ON_FAIL=1 -> done 17 cycles after start, vec frozen at 16, err_cnt=1.
REQ-033 Setup LAT=2, both models registered twice -> pass=1, done 34 cycles after start; with only q_m delayed 2 cycles -> err_cnt reflects the skewed compare.
REQ-034 rst_n=0 for one cycle at vec=9 mid-RUN -> all outputs at reset values next cycle; a new start gives a clean 32-vector run.
REQ-035 start pulsed at vec=5 mid-RUN -> no restart, vec sequence continues, done timing unchanged.
